// File: rtl/fpga_config_pkg.sv
// Shared definitions for the eFPGA configuration sink.
// Holds the default stream geometry, the word-count helper and the
// controller state encoding used by fpga_config_sink.
package fpga_config_pkg;

  localparam int BITSTREAM_LENGTH_DEF = 7286;
  localparam int WORD_WIDTH_DEF       = 32;

  // Number of words needed to hold a stream of a bits in b-bit words.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/cfg_deserializer.sv
// Serial-to-word packer for the configuration stream.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   clr_i         - re-arm (prog_rst): clears counter, partial word, excess
//   sample_i      - bit_i is a qualifying stream bit this cycle
//   flush_i       - end of stream: emit any partially filled word
//   bit_i         - serial configuration bit
//   word_done_o   - a word completes this cycle (combinational strobe)
//   word_data_o   - the completed word, LSB-first, zero-padded
//   count_o       - accepted bits, saturates at BITSTREAM_LENGTH
//   excess_o      - a bit arrived after the stream was already full
module cfg_deserializer
  import fpga_config_pkg::*;
#(
  parameter int BITSTREAM_LENGTH = BITSTREAM_LENGTH_DEF,
  parameter int WORD_WIDTH       = WORD_WIDTH_DEF,
  parameter int CNT_W            = $clog2(BITSTREAM_LENGTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  sample_i,
  input  logic                  flush_i,
  input  logic                  bit_i,
  output logic                  word_done_o,
  output logic [WORD_WIDTH-1:0] word_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  excess_o
);

  localparam int POS_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LEN      = CNT_W'(BITSTREAM_LENGTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BITSTREAM_LENGTH - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WORD_WIDTH - 1);

  logic [CNT_W-1:0]      cnt_q;
  logic [POS_W-1:0]      pos_q;
  logic [WORD_WIDTH-1:0] acc_q;
  logic [WORD_WIDTH-1:0] acc_d;
  logic                  excess_q;
  logic                  take;

  // The packing register only ever has bits below pos_q set, so the
  // upper bits of a short final word are already zero.
  always_comb begin
    take  = sample_i && (cnt_q != LEN);
    acc_d = acc_q;
    if (take) acc_d[pos_q] = bit_i;
    word_done_o = (take && ((pos_q == POS_LAST) || (cnt_q == LAST_IDX)))
               || (flush_i && (pos_q != '0));
  end

  assign word_data_o = acc_d;
  assign count_o     = cnt_q;
  assign excess_o    = excess_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q    <= '0;
      pos_q    <= '0;
      acc_q    <= '0;
      excess_q <= 1'b0;
    end else begin
      if (take) cnt_q <= cnt_q + 1'b1;
      if (word_done_o) begin
        acc_q <= '0;
        pos_q <= '0;
      end else if (take) begin
        acc_q <= acc_d;
        pos_q <= pos_q + 1'b1;
      end
      if (sample_i && !take) excess_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fpga_config_sink.sv
// Fabric-side receiver for the eFPGA serial configuration stream.
// Packs the prog bit stream into words, writes them to configuration
// memory, checks the stream length and releases the fabric on success.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   prog_rst, prog, fpga_rst         - loader interface
//   cfg_wr_en/addr/data, cfg_wr_ready - configuration memory write port
//   fabric_en, cfg_ok, cfg_err       - load status
//   dbg_state_o                      - current controller state
//
// Write port: cfg_wr_en is the valid. Once raised, cfg_wr_en, cfg_wr_addr
// and cfg_wr_data stay stable until a cycle with cfg_wr_en & cfg_wr_ready,
// which is the one and only transfer of that word.
module fpga_config_sink
  import fpga_config_pkg::*;
#(
  parameter int BITSTREAM_LENGTH = BITSTREAM_LENGTH_DEF,
  parameter int WORD_WIDTH       = WORD_WIDTH_DEF,
  parameter int NWORDS           = ceil_div(BITSTREAM_LENGTH, WORD_WIDTH),
  parameter int ADDR_WIDTH       = $clog2(NWORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_rst,
  input  logic                  prog,
  input  logic                  fpga_rst,
  output logic                  cfg_wr_en,
  output logic [ADDR_WIDTH-1:0] cfg_wr_addr,
  output logic [WORD_WIDTH-1:0] cfg_wr_data,
  input  logic                  cfg_wr_ready,
  output logic                  fabric_en,
  output logic                  cfg_ok,
  output logic                  cfg_err,
  output logic [2:0]            dbg_state_o
);

  localparam int CNT_W = $clog2(BITSTREAM_LENGTH) + 1;
  localparam logic [CNT_W-1:0] LEN = CNT_W'(BITSTREAM_LENGTH);

  cfg_state_e            state_q, state_d;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  overrun_q;
  logic                  fabric_en_q, ok_q, err_q;

  logic                  sample, flush;
  logic                  word_done;
  logic [WORD_WIDTH-1:0] word_data;
  logic [CNT_W-1:0]      bit_count;
  logic                  excess;

  assign sample = !prog_rst && fpga_rst
               && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  // The cycle that sees fpga_rst low in LOAD pushes out a partial word.
  assign flush  = !prog_rst && (state_q == ST_LOAD) && !fpga_rst;

  cfg_deserializer #(
    .BITSTREAM_LENGTH (BITSTREAM_LENGTH),
    .WORD_WIDTH       (WORD_WIDTH),
    .CNT_W            (CNT_W)
  ) u_deser (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (prog_rst),
    .sample_i    (sample),
    .flush_i     (flush),
    .bit_i       (prog),
    .word_done_o (word_done),
    .word_data_o (word_data),
    .count_o     (bit_count),
    .excess_o    (excess)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sample) state_d = ST_LOAD;
      ST_LOAD:  if (!fpga_rst) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (!wr_en_q) begin
          if ((bit_count == LEN) && !overrun_q && !excess) state_d = ST_DONE;
          else                                              state_d = ST_ERR;
        end
      end
      ST_DONE:  if (fpga_rst) state_d = ST_IDLE;
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_IDLE;
    endcase
    if (prog_rst) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Single holding register. A word completing while the previous one is
  // still waiting is accepted only if that previous one leaves this cycle.
  // The address advances for every completed word, dropped or not.
  always_ff @(posedge clk) begin
    if (rst || prog_rst) begin
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= '0;
      data_q      <= '0;
      overrun_q   <= 1'b0;
      fabric_en_q <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (word_done) begin
        next_addr_q <= next_addr_q + 1'b1;
        if (!wr_en_q || cfg_wr_ready) begin
          wr_en_q <= 1'b1;
          addr_q  <= next_addr_q;
          data_q  <= word_data;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (wr_en_q && cfg_wr_ready) begin
        wr_en_q <= 1'b0;
      end
      fabric_en_q <= (state_d == ST_DONE);
      ok_q        <= (state_d == ST_DONE);
      err_q       <= (state_d == ST_ERR);
    end
  end

  assign cfg_wr_en   = wr_en_q;
  assign cfg_wr_addr = addr_q;
  assign cfg_wr_data = data_q;
  assign fabric_en   = fabric_en_q;
  assign cfg_ok      = ok_q;
  assign cfg_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/fpga_config_sink.md
# fpga_config_sink

Fabric-side receiver for the eFPGA serial configuration stream. It samples the `prog` bit stream that the configuration loader drives while `prog_rst` is low and `fpga_rst` is high, and packs the bits LSB-first into words. It writes those words into the fabric configuration memory over a ready/valid write port, checks the received length against `BITSTREAM_LENGTH`, and releases the fabric (`fabric_en`) only after a complete, error-free load.

## Interface
Parameters:
- `BITSTREAM_LENGTH`, 7286: exact number of configuration bits per load.
- `WORD_WIDTH`, 32: configuration memory word width.
- `NWORDS`, derived as ceil(`BITSTREAM_LENGTH`/`WORD_WIDTH`), giving 228 at the defaults.
- `ADDR_WIDTH`, derived as $clog2(`NWORDS`), giving 8 at the defaults.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `prog_rst` in 1: configuration-chain reset from the loader. High aborts the load and re-arms the block.
- `prog` in 1: serial configuration bit, valid every cycle that `prog_rst`=0 and `fpga_rst`=1.
- `fpga_rst` in 1: fabric reset from the loader. Its falling edge marks the end of the stream.
- `cfg_wr_en` out 1: write valid.
- `cfg_wr_addr` out `ADDR_WIDTH`: word address.
- `cfg_wr_data` out `WORD_WIDTH`: word data.
- `cfg_wr_ready` in 1: memory accepts the word; a transfer occurs when `cfg_wr_en`&`cfg_wr_ready`.
- `fabric_en` out 1: configured fabric may run.
- `cfg_ok` out 1: last load was complete and clean.
- `cfg_err` out 1: last load failed.

## Operation
- Sample condition: `prog_rst`=0, `fpga_rst`=1, and state is IDLE or LOAD.
- Stream bit i goes to word i/`WORD_WIDTH`, at bit position i%`WORD_WIDTH`.
- A word is complete after `WORD_WIDTH` bits, or after bit `BITSTREAM_LENGTH`-1 is sampled. The final partial word is zero-padded; at the defaults, bits 22..31 of word 227 are 0.
- A completed word moves into a single output holding register and `cfg_wr_en` is asserted. The address increments on each completed word, starting at 0.
- Overrun: a word completes while the holding register still holds an untransferred word and `cfg_wr_ready`=0. The new word is dropped and the overrun flag is set. If `cfg_wr_ready`=1 in that same cycle, the old word transfers, the new word loads, and no error is raised.
- Excess: a bit is sampled when the bit count already equals `BITSTREAM_LENGTH`. The bit is discarded and the excess flag is set.

State machine:
- IDLE (entered on `rst`): when the sample condition holds, sample the bit and go to LOAD.
- LOAD: sample every qualifying cycle. When `fpga_rst` falls, go to FLUSH.
- FLUSH: wait until the holding register is empty. Then go to DONE if count == `BITSTREAM_LENGTH` and neither the overrun nor the excess flag is set; otherwise go to ERR.
- DONE: `fabric_en`=1 and `cfg_ok`=1. `fpga_rst`=1 moves to IDLE and clears `fabric_en`.
- ERR: `cfg_err`=1 and `fabric_en`=0. A write still pending is completed; no new writes are started.
- From any state, `prog_rst`=1 moves to IDLE. This clears the counters, the flags, the address, `cfg_ok`, `cfg_err` and `fabric_en`, and drops any pending write.

## Timing
- Reset values: `cfg_wr_en`=0, `cfg_wr_addr`=0, `cfg_wr_data`=0, `fabric_en`=0, `cfg_ok`=0, `cfg_err`=0, state IDLE, bit count 0.
- All outputs are registered.
- `cfg_wr_en` rises one cycle after the sample of the word's last bit.
- `cfg_wr_en`, `cfg_wr_addr` and `cfg_wr_data` hold stable until the transfer. `cfg_wr_en` falls in the cycle after the transfer unless a new word loads.
- Against the loader timing, the `BITSTREAM_LENGTH` bits arrive on consecutive cycles C1..CL and `fpga_rst` falls at C(L+1).
- `fabric_en` and `cfg_ok` rise one cycle after FLUSH sees an empty holding register. With `cfg_wr_ready` tied high, that is 2 cycles after `fpga_rst` falls.
- The bit counter is $clog2(`BITSTREAM_LENGTH`)+1 bits wide and saturates at `BITSTREAM_LENGTH`.
- `rst` mid-load returns all outputs to reset values in the next cycle.

## Structure
- Package `fpga_config_pkg` holds:
  - the `BITSTREAM_LENGTH` and `WORD_WIDTH` defaults;
  - the ceil-division function for `NWORDS`;
  - the state encoding IDLE/LOAD/FLUSH/DONE/ERR.
- Sub-module `cfg_deserializer` contains the shift register, bit counter, word-complete strobe, excess detection and zero-padding.
- The top level contains the FSM, the holding register, the write handshake and the status outputs.

## Test plan
- Nominal load: 7286 bits, with `cfg_wr_ready`=1 throughout.
  - Exactly 228 writes occur, at addresses 0..227.
  - Word data matches the packed stream, and word 227 bits 22..31 are 0.
  - `cfg_ok`=1 and `fabric_en`=1 two cycles after `fpga_rst` falls.
- Short stream: 7285 bits, then `fpga_rst` falls.
  - 228 writes occur, and the last word has bit 21 = 0.
  - `cfg_err`=1, `cfg_ok`=0 and `fabric_en`=0.
- Backpressure: `cfg_wr_ready`=0 for 40 cycles during word 5.
  - Overrun occurs; word 6 is dropped.
  - The FSM reaches ERR, and `cfg_err`=1 after the flush.
- Excess bit: 7287 qualifying bits.
  - Exactly 228 writes occur, and `cfg_err`=1.
- Abort: `prog_rst` pulses high after bit 3000, then a full 7286-bit stream follows.
  - Addresses restart at 0, and the second load ends with `cfg_ok`=1.
- `rst` asserted at bit 1000: all outputs are 0 in the next cycle and the FSM is in IDLE.
